// File: rtl/obuf_pkg.sv
// obuf_pkg: shared state encoding, limits and helpers for the tri-state output bank.
package obuf_pkg;
  typedef enum logic [1:0] {HIZ = 2'b00, TURN = 2'b01, DRIVE = 2'b10} obuf_state_t;
  localparam int OBUF_MAX_TURN = 15;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/obuf_turn_fsm.sv
// obuf_turn_fsm: bus-turnaround FSM inserting dead cycles before the bank drives.
module obuf_turn_fsm
  import obuf_pkg::*;
#(
  parameter int TURN_CYCLES = 2
) (
  input  logic        C,
  input  logic        CLR_N,
  input  logic        T,
  input  logic        GTS,
  output obuf_state_t state,
  output logic        DRV,
  output logic        BUSY
);
  localparam int TC = TURN_CYCLES > OBUF_MAX_TURN ? OBUF_MAX_TURN : TURN_CYCLES;
  localparam int CW = clog2(TC + 1) < 1 ? 1 : clog2(TC + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(TC == 0 ? 0 : TC - 1);
  obuf_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic go;
  assign go = !T && !GTS;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      HIZ: if (go) begin
        state_d = TC == 0 ? DRIVE : TURN;
        cnt_d = CNT_INIT;
      end
      TURN: begin
        state_d = !go ? HIZ : (cnt_q == '0 ? DRIVE : TURN);
        cnt_d = (go && cnt_q != '0) ? cnt_q - 1'b1 : '0;
      end
      DRIVE: state_d = go ? DRIVE : HIZ;
      default: state_d = HIZ;
    endcase
  end
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= HIZ;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // one bit per active state, so both flags come straight off flops
  assign state = state_q;
  assign DRV = state_q[1];
  assign BUSY = state_q[0];
endmodule

// File: rtl/obuft_bank_ta.sv
// obuft_bank_ta: WIDTH-bit registered tri-state output bank with bus turnaround and GTS.
module obuft_bank_ta
  import obuf_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               TURN_CYCLES = 2,
  parameter logic [WIDTH-1:0] INIT        = '0
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] I,
  input  logic             CE,
  input  logic             T,
  input  logic [WIDTH-1:0] M,
  input  tri0              GTS,
  output tri   [WIDTH-1:0] O,
  output logic             DRV,
  output logic             BUSY
);
  obuf_state_t state;
  logic [WIDTH-1:0] data_q, data_d;
  logic drive;
  obuf_turn_fsm #(.TURN_CYCLES(TURN_CYCLES)) u_fsm (
    .C(C), .CLR_N(CLR_N), .T(T), .GTS(GTS), .state(state), .DRV(DRV), .BUSY(BUSY)
  );
  assign data_d = CE ? I : data_q;
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) data_q <= INIT;
    else data_q <= data_d;
  end
  // GTS and M bypass the clock so the pad releases without waiting for an edge
  assign drive = state == DRIVE && !GTS;
  for (genvar k = 0; k < WIDTH; k++) begin : g_pad
    assign O[k] = (drive && !M[k]) ? data_q[k] : 1'bz;
  end
endmodule
